ifu: RTL

// - Instruction fetch unit. Produces the 32-bit instruction stream consumed by the decoder.
// - Issues word fetches on the instruction bus and buffers responses, paired with their PC, in a small FIFO.
// - Presents one instruction per cycle to decode over a valid/ready handshake.
// - Redirects on branch/jump/trap flush and discards stale in-flight responses.
//

---
 rtl/ifu_pkg.sv | 13 +
 rtl/ifu_sync_fifo.sv | 59 +++++
 rtl/ifu.sv | 120 ++++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] IFU_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            misalign;
  } ifu_entry_t;

endpackage

// File: rtl/ifu_sync_fifo.sv
// Register-based synchronous FIFO with a combinational head read.
// A clear may carry a push: the pushed word becomes the sole entry.
module ifu_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop, wr_en;
  logic [AW-1:0]    wr_idx;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign wr_en   = clear_i ? push_i : do_push;
  assign wr_idx  = clear_i ? '0 : wr_ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= push_i ? AW'(1) : '0;
      count_q  <= (AW+1)'(push_i);
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
    always_ff @(posedge clk) begin
      if (wr_en && wr_idx == AW'(gi)) mem_q[gi] <= wdata_i;
    end
  end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: credit-limited word fetch, response buffering and flush redirect.
// Optional IFU_MISALIGN_CHECK_EN: a misaligned redirect halts fetch and queues a flagged NOP.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ibus_req,
  output logic [31:0] ibus_addr,
  input  logic        ibus_ready,
  input  logic        ibus_rvalid,
  input  logic [31:0] ibus_rdata,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_misalign
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d, discard_q, discard_d;
  logic          halted_q, halted_d;
  logic [31:0]   flush_tgt;
  logic          flush_bad, accept, push, pop;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  ifu_entry_t    push_entry, head_entry;

`ifdef IFU_MISALIGN_CHECK_EN
  assign flush_tgt   = flush_pc;
  assign flush_bad   = |flush_pc[1:0];
  assign if_misalign = head_entry.misalign;
`else
  assign flush_tgt   = flush_pc & 32'hFFFF_FFFC;
  assign flush_bad   = 1'b0;
  assign if_misalign = head_entry.misalign & 1'b0;
`endif

  // Buffered plus in-flight words never exceed the FIFO, so every response has a slot.
  assign ibus_req  = ~rst & ~flush & ~halted_q &
                     (({1'b0, outstanding_q} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH));
  assign ibus_addr = fetch_pc_q;
  assign accept    = ibus_req & ibus_ready;
  assign pop       = ~fifo_empty & if_ready & ~flush;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    discard_d     = discard_q;
    halted_d      = halted_q;
    outstanding_d = outstanding_q + CW'(accept) - CW'(ibus_rvalid);
    push          = 1'b0;
    push_entry    = '{instr: ibus_rdata, pc: resp_pc_q, misalign: 1'b0};
    if (flush) begin
      // Everything still on the bus belongs to the old path and must be dropped.
      fetch_pc_d = flush_tgt;
      resp_pc_d  = flush_tgt;
      discard_d  = outstanding_d;
      halted_d   = flush_bad;
      if (flush_bad) begin
        push       = 1'b1;
        push_entry = '{instr: IFU_NOP, pc: flush_tgt, misalign: 1'b1};
      end
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
      if (ibus_rvalid) begin
        if (discard_q != '0) begin
          discard_d = discard_q - CW'(1);
        end else begin
          push      = ~fifo_full | pop;
          resp_pc_d = resp_pc_q + 32'd4;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_VECTOR;
      resp_pc_q     <= RESET_VECTOR;
      outstanding_q <= '0;
      discard_q     <= '0;
      halted_q      <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      halted_q      <= halted_d;
    end
  end

  ifu_sync_fifo #(
    .WIDTH($bits(ifu_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .clear_i(flush),
    .push_i (push),
    .pop_i  (pop),
    .wdata_i(push_entry),
    .rdata_o(head_entry),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  assign if_valid = ~fifo_empty;
  assign if_instr = head_entry.instr;
  assign if_pc    = head_entry.pc;

endmodule
